dmem_ctrl: RTL
==============

# dmem_ctrl

Multi-cycle load/store sequencer between the core's memory stage and the byte-wide data memory array. Accepts one word/half/byte load or store per request. Breaks each request into big-endian byte accesses on a single byte port, and reassembles read data with sign or zero extension. Rejects misaligned, out-of-range and illegal-size requests without touching memory.

## Interface
Parameters:
- ADDR_W, 14, byte-address width of the data memory (16384 bytes).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  1  request valid; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data; low-order bytes are used for half/byte.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse ending every accepted request.
- err  out  1  valid with done; 1 = request rejected.
- rdata  out  32  load result; valid with done; 0 for stores and errors.
- mem_addr  out  ADDR_W  byte address to the array.
- mem_re  out  1  byte read strobe; array returns mem_rdata one cycle later.
- mem_we  out  1  byte write strobe; written on the same edge.
- mem_wdata  out  8  byte to write.
- mem_rdata  in  8  byte read data (synchronous, 1-cycle latency).

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req=1 latches we, size, sign_ext, addr and wdata; N = 1/2/4 bytes.
  - An error is flagged if size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr+N-1 >= 2^ADDR_W.
  - Error → RESP with err=1. Otherwise we=1 → WRITE, we=0 → READ. Byte counter cnt=0.
- WRITE, one cycle per byte, cnt = 0..N-1:
  - mem_we=1, mem_addr=base+cnt.
  - mem_wdata is the big-endian byte cnt of the sized value. Word: base gets wdata[31:24] and base+3 gets wdata[7:0]. Half: base gets wdata[15:8]. Byte: wdata[7:0].
  - After cnt=N-1 → RESP.
- READ, N+1 cycles, cnt = 0..N:
  - When cnt<N: mem_re=1, mem_addr=base+cnt.
  - When cnt>=1: capture mem_rdata as byte cnt-1.
  - After cnt=N → RESP.
- Read assembly: byte 0 is the most significant. Half = {b0,b1}, byte = b0. Extend to 32 bits per sign_ext.
- RESP, one cycle: done=1, err and rdata driven; then → IDLE.
- mem_re, mem_we and mem_wdata are 0 outside their states; mem_addr is 0 in IDLE and RESP.
- Requester handshake:
  - Must hold request fields stable only on the accepting edge.
  - Must drop req in the done cycle; if req is still high, a new request is accepted on the following IDLE cycle.

## Timing
- Reset (asynchronous assert, any state): state=IDLE, cnt=0, and every output is 0 (busy, done, err, rdata, mem_*).
  - Takes effect immediately, with no completion pulse.
  - Bytes already written stay written; a partial store is possible and is not reported.
- Latency, counting cycles after the accepting edge, with done high in cycle:
  - Load: N+2 (byte 3, half 4, word 6).
  - Store: N+1 (byte 2, half 3, word 5).
  - Error: 1.
- Throughput: one request per N+3 (load) or N+2 (store) cycles, because of the mandatory IDLE cycle between requests.
- Address increment is ADDR_W bits wide and cannot wrap, because the range check rejects any request crossing the top.
- size=11 is an error regardless of we or addr.
- An error request never asserts mem_re or mem_we.

## Test plan
- Word store 0xDEADBEEF at 0x100:
  - mem_we for 4 cycles with addresses 0x100..0x103 and bytes DE, AD, BE, EF; done in cycle 5, err=0, rdata=0.
  - Word load at 0x100 then returns 0xDEADBEEF with done in cycle 6.
- Half loads at 0x102 after the above store:
  - sign_ext=1 → 0xFFFFBEEF.
  - sign_ext=0 → 0x0000BEEF.
  - Byte load at 0x101 with sign_ext=1 → 0xFFFFFFAD.
- Byte store with wdata=0x12345655 at 0x101, then word load at 0x100 → 0xDE55BEEF. Only one mem_we pulse, at address 0x101.
- Error cases, each giving done+err in cycle 1, rdata=0, and no mem_re/mem_we:
  - Misaligned word at 0x102.
  - Half at 0x3FFF.
  - Word at 0x4000.
  - size=11.
- rst_n pulled low during a word store after 2 bytes:
  - All outputs go to 0 at once, with no done.
  - Memory holds new bytes at base and base+1 only.
  - A fresh request after reset is handled normally.
- req held high across done with a second word load queued: the second request is accepted on the IDLE cycle after RESP and completes 6 cycles later with correct data.

Source files
------------

// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl
//
// Multi-cycle load/store sequencer between the core memory stage and a
// byte-wide data memory. A single request (byte/half/word, load or store)
// is split into big-endian byte accesses on one byte port. Load bytes are
// reassembled and sign- or zero-extended. Requests that are misaligned,
// out of range or of illegal size are rejected without touching memory.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req             request valid, sampled only while idle
//   we              1 = store, 0 = load
//   size            00 byte, 01 half, 10 word, 11 illegal
//   sign_ext        loads: 1 = sign-extend, 0 = zero-extend
//   addr, wdata     byte address, store data (low-order bytes for half/byte)
//   busy            high whenever the sequencer is not idle
//   done            one-cycle pulse ending every accepted request
//   err             valid with done; 1 = request rejected
//   rdata           load result, valid with done; 0 for stores and errors
//   mem_addr        byte address to the array
//   mem_re          byte read strobe, mem_rdata returns one cycle later
//   mem_we          byte write strobe, written on the same edge
//   mem_wdata       byte to write
//   mem_rdata       byte read data (1-cycle latency)
//   dbg_state       current FSM state (IDLE=0, READ=1, WRITE=2, RESP=3)
//
// Handshake: a request is accepted on the rising edge where the sequencer
// is idle and req=1; request fields need only be stable on that edge. The
// requester drops req in the done cycle; if req is still high then, the
// next request is accepted on the idle cycle that follows the response.
// ---------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_cnt;
    logic [2:0]         w_cnt_nxt;
    logic               r_we;
    logic [1:0]         r_size;
    logic               r_sign;
    logic               r_err;
    logic [ADDR_W-1:0]  r_base;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rbuf;    // byte 0 in [31:24], byte 3 in [7:0]

    // ---------------- request decode (used only in IDLE) ----------------
    logic [1:0]         w_req_nm1;
    logic [ADDR_W-1:0]  w_req_limit;
    logic               w_req_oor;
    logic               w_req_err;

    always_comb begin
        case (size)
            2'b01:   w_req_nm1 = 2'd1;
            2'b10:   w_req_nm1 = 2'd3;
            default: w_req_nm1 = 2'd0;
        endcase
    end

    // Highest legal base address for this size; comparing against it
    // avoids computing addr+N-1 and keeps the check free of carries.
    assign w_req_limit = {ADDR_W{1'b1}} - {{(ADDR_W-2){1'b0}}, w_req_nm1};
    assign w_req_oor   = (|addr[31:ADDR_W]) || (addr[ADDR_W-1:0] > w_req_limit);

    assign w_req_err = (size == 2'b11)
                    || ((size == 2'b01) && addr[0])
                    || ((size == 2'b10) && (addr[1:0] != 2'b00))
                    || w_req_oor;

    // ---------------- latched request helpers ----------------
    logic [2:0] w_last;      // N-1
    logic [2:0] w_nbytes;    // N
    logic [7:0] w_wbyte;
    logic [31:0] w_load;
    logic       w_addr_en;

    always_comb begin
        case (r_size)
            2'b01:   w_last = 3'd1;
            2'b10:   w_last = 3'd3;
            default: w_last = 3'd0;
        endcase
    end

    assign w_nbytes = w_last + 3'd1;

    // Big-endian byte cnt of the sized store value.
    always_comb begin
        case (r_size)
            2'b10: begin
                case (r_cnt[1:0])
                    2'd0:    w_wbyte = r_wdata[31:24];
                    2'd1:    w_wbyte = r_wdata[23:16];
                    2'd2:    w_wbyte = r_wdata[15:8];
                    default: w_wbyte = r_wdata[7:0];
                endcase
            end
            2'b01:   w_wbyte = r_cnt[0] ? r_wdata[7:0] : r_wdata[15:8];
            default: w_wbyte = r_wdata[7:0];
        endcase
    end

    // Read assembly: the first byte fetched is the most significant.
    always_comb begin
        case (r_size)
            2'b10:   w_load = r_rbuf;
            2'b01:   w_load = {{16{r_sign & r_rbuf[31]}}, r_rbuf[31:16]};
            default: w_load = {{24{r_sign & r_rbuf[31]}}, r_rbuf[31:24]};
        endcase
    end

    // ---------------- FSM: next state and memory strobes ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = 8'h00;
        w_addr_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_cnt_nxt = 3'd0;
                    if (w_req_err)
                        w_state_nxt = S_RESP;
                    else if (we)
                        w_state_nxt = S_WRITE;
                    else
                        w_state_nxt = S_READ;
                end
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_wdata = w_wbyte;
                w_addr_en = 1'b1;
                if (r_cnt == w_last) begin
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            S_READ: begin
                // One extra cycle after the last strobe to catch its data.
                if (r_cnt != w_nbytes) begin
                    mem_re    = 1'b1;
                    w_addr_en = 1'b1;
                end
                if (r_cnt == w_nbytes) begin
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // The range check guarantees base+cnt never passes the top of memory.
    assign mem_addr = w_addr_en ? (r_base + {{(ADDR_W-3){1'b0}}, r_cnt})
                                : {ADDR_W{1'b0}};

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_sign  <= 1'b0;
            r_err   <= 1'b0;
            r_base  <= {ADDR_W{1'b0}};
            r_wdata <= 32'h0;
            r_rbuf  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if ((r_state == S_IDLE) && req) begin
                r_we    <= we;
                r_size  <= size;
                r_sign  <= sign_ext;
                r_err   <= w_req_err;
                r_base  <= addr[ADDR_W-1:0];
                r_wdata <= wdata;
                r_rbuf  <= 32'h0;
            end
            if ((r_state == S_READ) && (r_cnt != 3'd0)) begin
                case (r_cnt)
                    3'd1:    r_rbuf[31:24] <= mem_rdata;
                    3'd2:    r_rbuf[23:16] <= mem_rdata;
                    3'd3:    r_rbuf[15:8]  <= mem_rdata;
                    default: r_rbuf[7:0]   <= mem_rdata;
                endcase
            end
        end
    end

    // ---------------- status outputs ----------------
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_RESP);
    assign err       = (r_state == S_RESP) && r_err;
    assign rdata     = ((r_state == S_RESP) && !r_err && !r_we) ? w_load : 32'h0;
    assign dbg_state = r_state;

endmodule
